// File: rtl/move_scanner_pkg.sv
// othello_pkg: cell codes, board size, scan states and the direction table shared by the move scanner
package othello_pkg;
  localparam int BOARD_N = 8;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  // direction order: E, W, S, N, SE, NW, SW, NE
  localparam logic signed [3:0] DIR_DROW [0:7] = '{4'sd0, 4'sd0, 4'sd1, -4'sd1, 4'sd1, -4'sd1, 4'sd1, -4'sd1};
  localparam logic signed [3:0] DIR_DCOL [0:7] = '{4'sd1, -4'sd1, 4'sd0, 4'sd0, 4'sd1, -4'sd1, -4'sd1, 4'sd1};
  localparam logic [4:0] DIR_STEP [0:7] = '{5'd1, 5'd1, 5'd8, 5'd8, 5'd9, 5'd9, 5'd7, 5'd7};
  // bit i is the flipper sign for direction i (1 = subtract); odd directions point backwards
  localparam logic [7:0] DIR_SIGN = 8'b1010_1010;
  typedef enum logic [3:0] {
    IDLE, CHK_RD, CHK_EV, DIR_INIT, STEP, RD, EVAL, ISSUE_LD, ISSUE_GO, WAIT_FLIP, NEXT_DIR, DONE
  } state_t;
  function automatic logic [1:0] own_code(input logic player);
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction
  function automatic logic [1:0] opp_code(input logic player);
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction
endpackage

// File: rtl/move_scanner_if.sv
// move_scanner_if: board-memory read port and flipper handshake; master = scanner, slave = memory/flipper side
interface move_scanner_if;
  logic       mem_own_o;
  logic [6:0] mem_addr_o;
  logic [1:0] mem_data_i;
  logic [6:0] fl_addr_o;
  logic [4:0] fl_step_o;
  logic       fl_sign_o;
  logic       fl_ld_o;
  logic       fl_start_o;
  logic       fl_done_i;
  modport master (
    output mem_own_o, mem_addr_o, fl_addr_o, fl_step_o, fl_sign_o, fl_ld_o, fl_start_o,
    input  mem_data_i, fl_done_i
  );
  modport slave (
    input  mem_own_o, mem_addr_o, fl_addr_o, fl_step_o, fl_sign_o, fl_ld_o, fl_start_o,
    output mem_data_i, fl_done_i
  );
endinterface

// File: rtl/move_scanner_dir_stepper.sv
// dir_stepper: combinational one-square step from (row,col) along dir; ports row/col/dir in, nrow/ncol/in_bounds/addr out
module dir_stepper
  import othello_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic [2:0] dir,
  output logic [2:0] nrow,
  output logic [2:0] ncol,
  output logic       in_bounds,
  output logic [6:0] addr
);
  logic signed [3:0] r, c;
  // -1 and 8 both have bit 3 set, so bit 3 flags leaving the board in either axis
  always_comb begin
    r = $signed({1'b0, row}) + DIR_DROW[dir];
    c = $signed({1'b0, col}) + DIR_DCOL[dir];
    nrow = r[2:0];
    ncol = c[2:0];
    in_bounds = !r[3] && !c[3];
    addr = {1'b0, r[2:0], c[2:0]};
  end
endmodule

// File: rtl/move_scanner.sv
// move_scanner: checks an Othello move in 8 directions and issues a flip job per capturing direction
// ports: clock/reset, start_i/player_i/move_addr_i request, busy_o/done_o/valid_o status, bus = memory + flipper
module move_scanner
  import othello_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  player_i,
  input  logic [6:0]            move_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  valid_o,
  move_scanner_if.master        bus
);
  state_t     state;
  logic       player_q;
  logic [6:0] addr_q;
  logic [2:0] dir, row, col, run;
  logic [2:0] nrow, ncol;
  logic [6:0] naddr;
  logic       in_bounds;
  dir_stepper u_step (.row(row), .col(col), .dir(dir), .nrow(nrow), .ncol(ncol), .in_bounds(in_bounds), .addr(naddr));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      player_q <= 1'b0;
      addr_q <= '0;
      dir <= '0;
      row <= '0;
      col <= '0;
      run <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      valid_o <= 1'b0;
      bus.mem_own_o <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.fl_addr_o <= '0;
      bus.fl_step_o <= '0;
      bus.fl_sign_o <= 1'b0;
      bus.fl_ld_o <= 1'b0;
      bus.fl_start_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start_i) begin
          player_q <= player_i;
          addr_q <= move_addr_i;
          valid_o <= 1'b0;
          busy_o <= 1'b1;
          bus.mem_own_o <= 1'b1;
          bus.mem_addr_o <= move_addr_i;
          state <= CHK_RD;
        end
        CHK_RD: state <= CHK_EV;
        CHK_EV: if (bus.mem_data_i != CELL_EMPTY) begin
          bus.mem_own_o <= 1'b0;
          done_o <= 1'b1;
          state <= DONE;
        end else begin
          dir <= '0;
          state <= DIR_INIT;
        end
        DIR_INIT: begin
          row <= addr_q[5:3];
          col <= addr_q[2:0];
          run <= '0;
          state <= STEP;
        end
        STEP: if (in_bounds) begin
          row <= nrow;
          col <= ncol;
          bus.mem_addr_o <= naddr;
          state <= RD;
        end else state <= NEXT_DIR;
        RD: state <= EVAL;
        // run counts opponents seen; a seventh opponent cannot be bracketed on an 8-wide board
        EVAL: if (bus.mem_data_i == opp_code(player_q) && run != 3'd6) begin
          run <= run + 3'd1;
          state <= STEP;
        end else if (bus.mem_data_i == own_code(player_q) && run != 3'd0) begin
          bus.mem_own_o <= 1'b0;
          bus.fl_addr_o <= addr_q;
          bus.fl_step_o <= DIR_STEP[dir];
          bus.fl_sign_o <= DIR_SIGN[dir];
          bus.fl_ld_o <= 1'b1;
          valid_o <= 1'b1;
          state <= ISSUE_LD;
        end else state <= NEXT_DIR;
        ISSUE_LD: begin
          bus.fl_ld_o <= 1'b0;
          bus.fl_start_o <= 1'b1;
          state <= ISSUE_GO;
        end
        ISSUE_GO: begin
          bus.fl_start_o <= 1'b0;
          state <= WAIT_FLIP;
        end
        WAIT_FLIP: if (bus.fl_done_i) begin
          bus.mem_own_o <= 1'b1;
          state <= NEXT_DIR;
        end
        NEXT_DIR: if (dir == 3'd7) begin
          bus.mem_own_o <= 1'b0;
          done_o <= 1'b1;
          state <= DONE;
        end else begin
          dir <= dir + 3'd1;
          state <= DIR_INIT;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_scanner.sv
// tb_move_scanner: directed scans against a board model, flip jobs checked through a scoreboard queue
module tb_move_scanner;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic player_i = 1'b0;
  logic [6:0] move_addr_i = '0;
  logic busy_o, done_o, valid_o;
  logic [1:0] board [0:63];
  logic [12:0] sb [$];
  logic [12:0] cur_job = '0;
  int passed = 0;
  int total = 0;
  int iss_cnt = 0;
  int flip_delay = 5;
  int fd_cnt = 0;
  logic fd_pulse = 1'b0;
  logic stray = 1'b0;
  move_scanner_if bus();
  move_scanner dut (
    .clock(clock), .reset(reset), .start_i(start_i), .player_i(player_i), .move_addr_i(move_addr_i),
    .busy_o(busy_o), .done_o(done_o), .valid_o(valid_o), .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) bus.mem_data_i <= board[bus.mem_addr_o[5:0]];
  assign bus.fl_done_i = fd_pulse | stray;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fd_cnt <= 0;
      fd_pulse <= 1'b0;
    end else begin
      fd_pulse <= (fd_cnt == 1);
      if (bus.fl_start_o) fd_cnt <= flip_delay;
      else if (fd_cnt > 0) fd_cnt <= fd_cnt - 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(negedge clock) begin
    if (bus.fl_ld_o) begin
      iss_cnt++;
      cur_job = (sb.size() > 0) ? sb.pop_front() : 13'h1fff;
      chk("issue", {19'd0, bus.fl_addr_o, bus.fl_step_o, bus.fl_sign_o}, {19'd0, cur_job});
    end
    if (fd_pulse) begin
      chk("held at done", {19'd0, bus.fl_addr_o, bus.fl_step_o, bus.fl_sign_o}, {19'd0, cur_job});
      chk("own in wait", {31'd0, bus.mem_own_o}, 32'd0);
    end
  end
  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
  endtask
  task automatic init_board();
    clear_board();
    board[27] = 2'b10; board[36] = 2'b10; board[28] = 2'b01; board[35] = 2'b01;
  endtask
  task automatic scan(input string tag, input logic pl, input logic [6:0] a, input logic exp_valid,
                      input int exp_iss, input int exp_lat);
    int cyc;
    logic got;
    iss_cnt = 0;
    start_i = 1'b1; player_i = pl; move_addr_i = a;
    @(negedge clock);
    start_i = 1'b0; stray = 1'b0;
    chk({tag, " busy"}, {31'd0, busy_o}, 32'd1);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      got = done_o;
    end
    chk({tag, " done"}, {31'd0, got}, 32'd1);
    if (exp_lat >= 0) chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " valid"}, {31'd0, valid_o}, {31'd0, exp_valid});
    chk({tag, " issues"}, iss_cnt, exp_iss);
    chk({tag, " sb left"}, sb.size(), 0);
    @(negedge clock);
    chk({tag, " done pulse"}, {30'd0, done_o, busy_o}, 32'd0);
    chk({tag, " valid held"}, {31'd0, valid_o}, {31'd0, exp_valid});
    sb.delete();
  endtask
  initial begin
    init_board();
    repeat (2) @(negedge clock);
    chk("reset status", {29'd0, busy_o, done_o, valid_o}, 32'd0);
    chk("reset bus", {13'd0, bus.mem_own_o, bus.mem_addr_o, bus.fl_ld_o, bus.fl_start_o, bus.fl_addr_o, bus.fl_step_o, bus.fl_sign_o}, 32'd0);
    reset = 1'b0;
    sb.push_back({7'd19, 5'd8, 1'b0});
    scan("b19", 1'b0, 7'd19, 1'b1, 1, -1);
    scan("b0", 1'b0, 7'd0, 1'b0, 0, -1);
    scan("b27 occupied", 1'b0, 7'd27, 1'b0, 0, 2);
    sb.push_back({7'd20, 5'd8, 1'b0});
    scan("w20", 1'b1, 7'd20, 1'b1, 1, -1);
    stray = 1'b1;
    sb.push_back({7'd26, 5'd1, 1'b0});
    scan("b26 stray done", 1'b0, 7'd26, 1'b1, 1, -1);
    clear_board();
    board[8] = 2'b10; board[9] = 2'b01;
    scan("b7 no wrap", 1'b0, 7'd7, 1'b0, 0, -1);
    clear_board();
    board[1] = 2'b10; board[9] = 2'b10; board[2] = 2'b01; board[18] = 2'b01;
    sb.push_back({7'd0, 5'd1, 1'b0});
    sb.push_back({7'd0, 5'd9, 1'b0});
    scan("b0 two", 1'b0, 7'd0, 1'b1, 2, -1);
    clear_board();
    board[0] = 2'b01;
    for (int i = 1; i < 7; i++) board[i] = 2'b10;
    sb.push_back({7'd7, 5'd1, 1'b1});
    scan("b7 long west", 1'b0, 7'd7, 1'b1, 1, -1);
    clear_board();
    for (int i = 1; i < 8; i++) board[i] = 2'b10;
    scan("b0 run to edge", 1'b0, 7'd0, 1'b0, 0, -1);
    init_board();
    flip_delay = 40;
    iss_cnt = 0;
    sb.push_back({7'd19, 5'd8, 1'b0});
    start_i = 1'b1; player_i = 1'b0; move_addr_i = 7'd19;
    @(negedge clock);
    start_i = 1'b0;
    for (int i = 0; i < 200 && !bus.fl_start_o; i++) @(negedge clock);
    chk("rst flip started", {31'd0, bus.fl_start_o}, 32'd1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst status", {29'd0, busy_o, done_o, valid_o}, 32'd0);
    chk("rst bus", {13'd0, bus.mem_own_o, bus.mem_addr_o, bus.fl_ld_o, bus.fl_start_o, bus.fl_addr_o, bus.fl_step_o, bus.fl_sign_o}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    flip_delay = 5;
    sb.push_back({7'd19, 5'd8, 1'b0});
    scan("after rst", 1'b0, 7'd19, 1'b1, 1, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
